// File: rtl/drive_level_ctrl.sv
// Pedal/gear front end for the servo speed command: debounces four buttons,
// tracks gear and ceiling, and ramps speed_level per drive state.

module drive_level_ctrl_deb #(
    parameter int DEB_CYCLES = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic lvl_nxt_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q, lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips on the DEB_CYCLES-th consecutive clock of disagreement.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) lvl_d = sync2_q;
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lvl_nxt_o = lvl_d;
endmodule

module drive_level_ctrl #(
    parameter int DEB_CYCLES   = 200,
    parameter int ACCEL_CYCLES = 1000,
    parameter int BRAKE_CYCLES = 500,
    parameter int COAST_CYCLES = 3000,
    parameter int BASE_MAX     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_accel,
    input  logic       btn_brake,
    input  logic       btn_gear_up,
    input  logic       btn_gear_dn,
    output logic [3:0] speed_level,
    output logic [3:0] max_level,
    output logic [1:0] gear,
    output logic [1:0] drive_state
);
    localparam int NB    = 4;
    localparam int B_ACC = 0;
    localparam int B_BRK = 1;
    localparam int B_GUP = 2;
    localparam int B_GDN = 3;
    localparam int PMAX  = (ACCEL_CYCLES > BRAKE_CYCLES) ?
                           ((ACCEL_CYCLES > COAST_CYCLES) ? ACCEL_CYCLES : COAST_CYCLES) :
                           ((BRAKE_CYCLES > COAST_CYCLES) ? BRAKE_CYCLES : COAST_CYCLES);
    localparam int TW    = $clog2(PMAX + 1);
    localparam logic [TW-1:0] ACC_LAST = TW'(ACCEL_CYCLES - 1);
    localparam logic [TW-1:0] BRK_LAST = TW'(BRAKE_CYCLES - 1);
    localparam logic [TW-1:0] CST_LAST = TW'(COAST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCEL = 2'd1, BRAKE = 2'd2, COAST = 2'd3} state_e;

    logic [NB-1:0] btn_raw, lvl_nxt;
    logic [1:0]    gbtn_q, gbtn_d, grise;
    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_last;
    logic [3:0]    speed_q, speed_d, max_q, max_d;
    logic [1:0]    gear_q, gear_d;
    logic          step;

    assign btn_raw = {btn_gear_dn, btn_gear_up, btn_brake, btn_accel};

    for (genvar g = 0; g < NB; g++) begin : g_deb
        drive_level_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk       (clk),
            .rst       (rst),
            .raw_i     (btn_raw[g]),
            .lvl_nxt_o (lvl_nxt[g])
        );
    end

    // Everything keys off the next debounced level so it lands on the same edge.
    assign gbtn_d = {lvl_nxt[B_GDN], lvl_nxt[B_GUP]};
    assign grise  = gbtn_d & ~gbtn_q;

    always_comb begin
        gear_d = gear_q;
        if (grise[0] && !grise[1] && gear_q != 2'd3)      gear_d = gear_q + 2'd1;
        else if (grise[1] && !grise[0] && gear_q != 2'd0) gear_d = gear_q - 2'd1;
        max_d = 4'(BASE_MAX) + {1'b0, gear_d, 1'b0};

        if (lvl_nxt[B_BRK])      state_d = BRAKE;
        else if (lvl_nxt[B_ACC]) state_d = ACCEL;
        else if (speed_q != '0)  state_d = COAST;
        else                     state_d = IDLE;

        case (state_q)
            ACCEL:   tmr_last = ACC_LAST;
            BRAKE:   tmr_last = BRK_LAST;
            COAST:   tmr_last = CST_LAST;
            default: tmr_last = '0;
        endcase

        step  = 1'b0;
        tmr_d = tmr_q + 1'b1;
        if (state_d != state_q || state_q == IDLE) begin
            tmr_d = '0;
        end else if (tmr_q == tmr_last) begin
            tmr_d = '0;
            step  = 1'b1;
        end

        speed_d = speed_q;
        if (step) begin
            if (state_q == ACCEL) begin
                if (speed_q < max_d) speed_d = speed_q + 4'd1;
            end else if (speed_q != '0) begin
                speed_d = speed_q - 4'd1;
            end
        end
        // A gear-down can drop the ceiling below the current speed.
        if (speed_d > max_d) speed_d = max_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            speed_q <= '0;
            gear_q  <= '0;
            max_q   <= 4'(BASE_MAX);
            gbtn_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            speed_q <= speed_d;
            gear_q  <= gear_d;
            max_q   <= max_d;
            gbtn_q  <= gbtn_d;
        end
    end

    assign speed_level = speed_q;
    assign max_level   = max_q;
    assign gear        = gear_q;
    assign drive_state = state_q;
endmodule

// File: tb/tb_drive_level_ctrl.sv
// Bench for drive_level_ctrl: directed scenarios with constant expectations
// plus a randomized run compared cycle by cycle against a behavioural model.

module tb_drive_level_ctrl;
    localparam int DEB  = 200;
    localparam int ACC  = 1000;
    localparam int BRK  = 500;
    localparam int CST  = 3000;
    localparam int BMAX = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_accel = 1'b0, btn_brake = 1'b0, btn_gear_up = 1'b0, btn_gear_dn = 1'b0;
    logic [3:0] speed_level, max_level;
    logic [1:0] gear, drive_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: sync stages, debounced level and disagreement run per button.
    int m_s1[4], m_s2[4], m_deb[4], m_run[4];
    int m_gear, m_speed, m_st, m_tmr;

    drive_level_ctrl #(
        .DEB_CYCLES(DEB), .ACCEL_CYCLES(ACC), .BRAKE_CYCLES(BRK),
        .COAST_CYCLES(CST), .BASE_MAX(BMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_accel(btn_accel), .btn_brake(btn_brake),
        .btn_gear_up(btn_gear_up), .btn_gear_dn(btn_gear_dn),
        .speed_level(speed_level), .max_level(max_level),
        .gear(gear), .drive_state(drive_state)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int raw[4];
        int nd[4];
        int rise[4];
        int nst, per, maxl;
        bit stp;
        raw[0] = int'(btn_accel);
        raw[1] = int'(btn_brake);
        raw[2] = int'(btn_gear_up);
        raw[3] = int'(btn_gear_dn);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
            end
            m_gear = 0; m_speed = 0; m_st = 0; m_tmr = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            nd[i] = m_deb[i];
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    nd[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            rise[i] = (nd[i] == 1 && m_deb[i] == 0) ? 1 : 0;
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
            m_deb[i] = nd[i];
        end
        if (rise[2] == 1 && rise[3] == 0)      m_gear = (m_gear < 3) ? m_gear + 1 : 3;
        else if (rise[3] == 1 && rise[2] == 0) m_gear = (m_gear > 0) ? m_gear - 1 : 0;
        maxl = BMAX + 2 * m_gear;
        nst  = (nd[1] == 1) ? 2 : (nd[0] == 1) ? 1 : (m_speed > 0) ? 3 : 0;
        per  = (m_st == 1) ? ACC : (m_st == 2) ? BRK : CST;
        stp  = 1'b0;
        if (nst != m_st || m_st == 0) begin
            m_tmr = 0;
        end else begin
            m_tmr++;
            if (m_tmr == per) begin
                stp = 1'b1;
                m_tmr = 0;
            end
        end
        if (stp) begin
            if (m_st == 1) m_speed = (m_speed + 1 > maxl) ? maxl : m_speed + 1;
            else           m_speed = (m_speed > 0) ? m_speed - 1 : 0;
        end
        if (m_speed > maxl) m_speed = maxl;
        m_st = nst;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        btn_accel = 0; btn_brake = 0; btn_gear_up = 0; btn_gear_dn = 0;
        rst = 1'b1;
        tick(3);
        n_tests++;
        if ({speed_level, max_level, gear, drive_state} !== {4'd0, 4'd5, 2'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: spd=%0d max=%0d gear=%0d st=%0d want 0 5 0 0",
                     speed_level, max_level, gear, drive_state);
        end
        rst = 1'b0;
        repeat (5000) begin
            tick(1);
            if ({speed_level, max_level, gear, drive_state} !== {4'd0, 4'd5, 2'd0, 2'd0}) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_5000: %0d cycles off idle, want 0", bad);
        end
    endtask

    task automatic test_accel();
        int over = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            btn_accel = (i % 2 == 0);
            tick(1);
        end
        btn_accel = 1'b1;
        tick(DEB + 1);
        n_tests++;
        if (drive_state !== 2'd0) begin
            n_fail++; $display("FAIL accel_early: st=%0d want 0", drive_state);
        end
        tick(1);
        n_tests++;
        if (drive_state !== 2'd1 || speed_level !== 4'd0) begin
            n_fail++; $display("FAIL accel_entry: st=%0d spd=%0d want 1 0", drive_state, speed_level);
        end
        for (int k = 1; k <= 5; k++) begin
            tick(ACC - 1);
            n_tests++;
            if (speed_level !== 4'(k - 1)) begin
                n_fail++; $display("FAIL accel_pre_step%0d: spd=%0d want %0d", k, speed_level, k - 1);
            end
            tick(1);
            n_tests++;
            if (speed_level !== 4'(k)) begin
                n_fail++; $display("FAIL accel_step%0d: spd=%0d want %0d", k, speed_level, k);
            end
        end
        repeat (2500) begin
            tick(1);
            if (speed_level > 4'd5) over++;
        end
        n_tests++;
        if (over != 0 || speed_level !== 4'd5) begin
            n_fail++; $display("FAIL accel_saturate: spd=%0d over=%0d want 5 0", speed_level, over);
        end
    endtask

    task automatic test_gear_up();
        int over = 0;
        for (int p = 0; p < 2; p++) begin
            btn_gear_up = 1'b1;
            tick(DEB + 1);
            n_tests++;
            if (gear !== 2'(p)) begin
                n_fail++; $display("FAIL gear_up_early%0d: gear=%0d want %0d", p, gear, p);
            end
            tick(1);
            n_tests++;
            if (gear !== 2'(p + 1) || max_level !== 4'(BMAX + 2 * (p + 1))) begin
                n_fail++; $display("FAIL gear_up%0d: gear=%0d max=%0d want %0d %0d",
                                   p, gear, max_level, p + 1, BMAX + 2 * (p + 1));
            end
            tick(98);
            btn_gear_up = 1'b0;
            tick(300);
            n_tests++;
            if (gear !== 2'(p + 1)) begin
                n_fail++; $display("FAIL gear_up_hold%0d: gear=%0d want %0d", p, gear, p + 1);
            end
        end
        repeat (5000) begin
            tick(1);
            if (speed_level > max_level) over++;
        end
        n_tests++;
        if (speed_level !== 4'd9 || max_level !== 4'd9 || over != 0) begin
            n_fail++; $display("FAIL gear_up_ramp: spd=%0d max=%0d over=%0d want 9 9 0",
                               speed_level, max_level, over);
        end
    endtask

    task automatic test_gear_dn();
        btn_gear_dn = 1'b1;
        tick(DEB + 1);
        n_tests++;
        if (gear !== 2'd2 || speed_level !== 4'd9) begin
            n_fail++; $display("FAIL gear_dn_early: gear=%0d spd=%0d want 2 9", gear, speed_level);
        end
        tick(1);
        n_tests++;
        if (gear !== 2'd1 || max_level !== 4'd7 || speed_level !== 4'd7) begin
            n_fail++; $display("FAIL gear_dn_clamp: gear=%0d max=%0d spd=%0d want 1 7 7",
                               gear, max_level, speed_level);
        end
        btn_gear_dn = 1'b0;
        tick(1500);
        n_tests++;
        if (gear !== 2'd1 || speed_level !== 4'd7) begin
            n_fail++; $display("FAIL gear_dn_hold: gear=%0d spd=%0d want 1 7", gear, speed_level);
        end
    endtask

    task automatic test_brake_both();
        btn_accel = 1'b0;
        apply_reset();
        btn_accel = 1'b1;
        tick(DEB + 2 + 4 * ACC);
        n_tests++;
        if (speed_level !== 4'd4 || drive_state !== 2'd1) begin
            n_fail++; $display("FAIL brake_setup: spd=%0d st=%0d want 4 1", speed_level, drive_state);
        end
        btn_brake = 1'b1;
        tick(DEB + 2);
        n_tests++;
        if (drive_state !== 2'd2 || speed_level !== 4'd4) begin
            n_fail++; $display("FAIL brake_entry: st=%0d spd=%0d want 2 4", drive_state, speed_level);
        end
        tick(BRK - 1);
        n_tests++;
        if (speed_level !== 4'd4) begin
            n_fail++; $display("FAIL brake_pre_step: spd=%0d want 4", speed_level);
        end
        tick(1);
        n_tests++;
        if (speed_level !== 4'd3) begin
            n_fail++; $display("FAIL brake_step1: spd=%0d want 3", speed_level);
        end
        tick(3 * BRK);
        n_tests++;
        if (speed_level !== 4'd0 || drive_state !== 2'd2) begin
            n_fail++; $display("FAIL brake_zero: spd=%0d st=%0d want 0 2", speed_level, drive_state);
        end
        btn_accel = 1'b0;
        btn_brake = 1'b0;
        tick(DEB + 2);
        n_tests++;
        if (drive_state !== 2'd0 || speed_level !== 4'd0) begin
            n_fail++; $display("FAIL brake_release: st=%0d spd=%0d want 0 0", drive_state, speed_level);
        end
    endtask

    task automatic test_coast();
        btn_accel = 1'b0;
        apply_reset();
        btn_accel = 1'b1;
        tick(DEB + 2 + 2 * ACC);
        btn_accel = 1'b0;
        tick(DEB + 2);
        n_tests++;
        if (drive_state !== 2'd3 || speed_level !== 4'd2) begin
            n_fail++; $display("FAIL coast_entry: st=%0d spd=%0d want 3 2", drive_state, speed_level);
        end
        tick(CST - 1);
        n_tests++;
        if (speed_level !== 4'd2) begin
            n_fail++; $display("FAIL coast_pre_step: spd=%0d want 2", speed_level);
        end
        tick(1);
        n_tests++;
        if (speed_level !== 4'd1) begin
            n_fail++; $display("FAIL coast_step1: spd=%0d want 1", speed_level);
        end
        tick(CST);
        n_tests++;
        if (speed_level !== 4'd0) begin
            n_fail++; $display("FAIL coast_step2: spd=%0d want 0", speed_level);
        end
        tick(1);
        n_tests++;
        if (drive_state !== 2'd0) begin
            n_fail++; $display("FAIL coast_idle: st=%0d want 0", drive_state);
        end
    endtask

    task automatic test_reset_mid();
        btn_accel = 1'b0;
        apply_reset();
        btn_gear_up = 1'b1;
        tick(DEB + 2);
        btn_gear_up = 1'b0;
        btn_accel = 1'b1;
        tick(DEB + 2 + 2 * ACC);
        btn_accel = 1'b0;
        tick(DEB + 2 + 1500);
        n_tests++;
        if (drive_state !== 2'd3 || gear !== 2'd1 || speed_level !== 4'd2) begin
            n_fail++; $display("FAIL rst_mid_setup: st=%0d gear=%0d spd=%0d want 3 1 2",
                               drive_state, gear, speed_level);
        end
        rst = 1'b1;
        btn_accel = 1'b1;
        tick(1);
        n_tests++;
        if ({speed_level, max_level, gear, drive_state} !== {4'd0, 4'd5, 2'd0, 2'd0}) begin
            n_fail++; $display("FAIL rst_mid: spd=%0d max=%0d gear=%0d st=%0d want 0 5 0 0",
                               speed_level, max_level, gear, drive_state);
        end
        tick(1);
        rst = 1'b0;
        tick(DEB + 1);
        n_tests++;
        if (drive_state !== 2'd0) begin
            n_fail++; $display("FAIL rst_hold_early: st=%0d want 0", drive_state);
        end
        tick(1);
        n_tests++;
        if (drive_state !== 2'd1) begin
            n_fail++; $display("FAIL rst_hold_redeb: st=%0d want 1", drive_state);
        end
        btn_accel = 1'b0;
    endtask

    task automatic test_random();
        int cyc = 0;
        int len;
        int shown = 0;
        btn_accel = 0; btn_brake = 0; btn_gear_up = 0; btn_gear_dn = 0;
        apply_reset();
        while (cyc < 20000) begin
            btn_accel   = ($urandom_range(0, 2) != 0);
            btn_brake   = ($urandom_range(0, 3) == 0);
            btn_gear_up = ($urandom_range(0, 5) == 0);
            btn_gear_dn = ($urandom_range(0, 5) == 0);
            rst         = ($urandom_range(0, 39) == 0);
            len = $urandom_range(1, 900);
            for (int c = 0; c < len; c++) begin
                if (c == 1) rst = 1'b0;
                if (c < 8 && $urandom_range(0, 2) == 0) btn_accel = ~btn_accel;
                tick(1);
                cyc++;
                n_tests++;
                if (speed_level !== 4'(m_speed) || max_level !== 4'(BMAX + 2 * m_gear) ||
                    gear !== 2'(m_gear) || drive_state !== 2'(m_st)) begin
                    n_fail++;
                    if (shown < 10)
                        $display("FAIL rand_cyc%0d: spd=%0d max=%0d gear=%0d st=%0d want %0d %0d %0d %0d",
                                 cyc, speed_level, max_level, gear, drive_state,
                                 m_speed, BMAX + 2 * m_gear, m_gear, m_st);
                    shown++;
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_accel();
        test_gear_up();
        test_gear_dn();
        test_brake_both();
        test_coast();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/drive_level_ctrl.md
DRIVE_LEVEL_CTRL -- requirements
Module: drive_level_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 200, meaning button stable time in clocks (20 ms at 10 kHz).
REQ-002 The block SHALL have parameter ACCEL_CYCLES, default 1000, meaning clocks per speed_level increment while accelerating.
REQ-003 The block SHALL have parameter BRAKE_CYCLES, default 500, meaning clocks per speed_level decrement while braking.
REQ-004 The block SHALL have parameter COAST_CYCLES, default 3000, meaning clocks per speed_level decrement with no pedal.
REQ-005 The block SHALL have parameter BASE_MAX, default 5, meaning max_level in gear 0.
REQ-006 The block SHALL have port clk, input, 1, the single 10 kHz system clock.
REQ-007 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-008 The block SHALL have port btn_accel, input, 1, raw asynchronous accelerator button, high = pressed.
REQ-009 The block SHALL have port btn_brake, input, 1, raw asynchronous brake button, high = pressed.
REQ-010 The block SHALL have port btn_gear_up, input, 1, raw asynchronous gear-up button.
REQ-011 The block SHALL have port btn_gear_dn, input, 1, raw asynchronous gear-down button.
REQ-012 The block SHALL have port speed_level, output, 4, registered speed command to servo_rpm_ctrl.
REQ-013 The block SHALL have port max_level, output, 4, registered gear ceiling to servo_rpm_ctrl.
REQ-014 The block SHALL have port gear, output, 2, current gear 0..3.
REQ-015 The block SHALL have port drive_state, output, 2, FSM state: 0 IDLE, 1 ACCEL, 2 BRAKE, 3 COAST.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive clocks; any bounce restarts the count.
REQ-017 Debounced-level latency SHALL be exactly 2 + DEB_CYCLES clocks from a clean raw edge.
REQ-018 Gear buttons SHALL act on debounced rising edge only, one gear step per press, regardless of hold time.
REQ-019 gear SHALL saturate at 0 and 3; max_level SHALL equal BASE_MAX + 2*gear, updating on the same edge as gear.
REQ-020 Simultaneous debounced gear-up and gear-down edges SHALL be ignored (no change).
REQ-021 If a gear-down makes new max_level < speed_level, speed_level SHALL be clamped to the new max_level on that same edge.
REQ-022 FSM next state, evaluated every clock from debounced levels: brake pressed -> BRAKE; else accel pressed -> ACCEL; else speed_level > 0 -> COAST; else IDLE.
REQ-023 Brake SHALL win over accel when both are pressed.
REQ-024 A step timer SHALL reset to 0 on every state change and otherwise count up; on reaching period-1 (period per state: ACCEL_CYCLES, BRAKE_CYCLES, COAST_CYCLES) it SHALL step speed_level and wrap to 0.
REQ-025 First step after entering a state SHALL be visible exactly period clocks after entry.
REQ-026 ACCEL step: speed_level +1, saturating at max_level; BRAKE/COAST step: -1, saturating at 0.
REQ-027 In IDLE the timer SHALL hold at 0 and speed_level SHALL stay 0.
REQ-028 Gear change SHALL NOT reset the step timer.
REQ-029 speed_level SHALL never exceed max_level and SHALL never wrap.

Reset
REQ-030 While rst is high at a clk edge: speed_level 0, gear 0, max_level BASE_MAX (5), drive_state IDLE, timer 0, synchronizers and debounced levels 0, debounce counters 0.
REQ-031 Reset asserted mid-ramp or mid-debounce SHALL abort it; a button held through reset SHALL be re-debounced (2 + DEB_CYCLES) after release of rst.

Verification
REQ-032 Reset, no buttons, 5000 clocks -> speed_level 0, max_level 5, gear 0, drive_state 0 throughout.
REQ-033 Hold btn_accel with 10-clock bounce at start -> ACCEL 202 clocks after last bounce; speed_level 1,2,3 at +1000,+2000,+3000; saturates at 5, never 6.
REQ-034 At speed 5, press btn_gear_up twice (each held 300 clocks) -> gear 2, max_level 9; accel continues to 9.
REQ-035 At speed 9 gear 2, press btn_gear_dn once -> gear 1, max_level 7, speed_level 7 on the same edge.
REQ-036 Hold accel and brake together from speed 4 -> BRAKE; speed 3 after 500 clocks, 0 after 2000; release both -> IDLE.
REQ-037 Release all at speed 2 -> COAST, speed 1 at +3000, 0 at +6000, then IDLE; assert rst mid-COAST -> all outputs to reset values next edge.
